rampa_corriente_pwm: RTL and testbench

//  Downstream consumer of the current-setpoint memory.
//  - Takes the selected 10-bit current target I_obj.
//  - Slews an internal setpoint I_act toward I_obj at a bounded rate (soft start/stop).
//  - Drives a PWM output whose duty equals I_act / 1023.
//  - Sits between the setpoint lookup and the power-stage gate driver.

---
 rtl/rampa_corriente_pwm_pkg.sv | 14 +
 rtl/rampa_corriente_pwm_pwm_gen.sv | 28 ++
 rtl/rampa_corriente_pwm.sv | 117 +++++++++++
 tb/tb_rampa_corriente_pwm.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rampa_corriente_pwm_pkg.sv
// Shared definitions for the current ramp / PWM block: FSM state encoding and
// the default datapath width.
package rampa_corriente_pwm_pkg;

    localparam int W_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SUBIR   = 2'd1,
        ST_BAJAR   = 2'd2,
        ST_ESTABLE = 2'd3
    } estado_t;

endpackage

// File: rtl/rampa_corriente_pwm_pwm_gen.sv
// PWM generator: free-running counter over 0..2^W-2 (period 2^W-1 clocks) and a
// registered compare against duty, so duty=0 is always low and duty=2^W-1 always high.
module pwm_gen
    import rampa_corriente_pwm_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] duty,
    output logic         pwm
);

    localparam logic [W-1:0] CNT_LAST = {{(W-1){1'b1}}, 1'b0};

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            pwm <= 1'b0;
        end else begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            pwm <= (cnt < duty);
        end
    end

endmodule

// File: rtl/rampa_corriente_pwm.sv
// Slew-limited current setpoint with PWM output. Defining SOFT_LIMIT_EN clamps
// the incoming target to I_MAX; otherwise the full code range is passed through.
//
// state      | meaning
// ST_IDLE    | disabled and setpoint at zero
// ST_SUBIR   | setpoint below target, ramping up
// ST_BAJAR   | setpoint above target, ramping down
// ST_ESTABLE | enabled and setpoint equal to target
module rampa_corriente_pwm
    import rampa_corriente_pwm_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int STEP     = 8,
    parameter int TICK_DIV = 1000,
    parameter int I_MAX    = 900
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] I_obj,
    output logic [W-1:0] I_act,
    output logic         pwm,
    output logic         listo,
    output logic [1:0]   estado
);

    localparam int             TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [W:0]     STEP_X    = (W + 1)'(STEP);

    if (TICK_DIV < 2 || I_MAX > (1 << W) - 1) begin : g_bad_param
        $error("rampa_corriente_pwm: TICK_DIV must be >= 2 and I_MAX must fit in W bits");
    end

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [W-1:0]  obj_lim;
    logic [W-1:0]  tgt;
    logic [W:0]    act_x;
    logic [W:0]    tgt_x;
    logic [W:0]    diff;
    logic [W-1:0]  act_nxt;
    logic          listo_nxt;
    estado_t       state;
    estado_t       state_nxt;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

`ifdef SOFT_LIMIT_EN
    assign obj_lim = (I_obj > W'(I_MAX)) ? W'(I_MAX) : I_obj;
`else
    assign obj_lim = I_obj;
`endif

    assign tgt   = en ? obj_lim : '0;
    assign act_x = {1'b0, I_act};
    assign tgt_x = {1'b0, tgt};

    // Step is min(STEP, distance) in W+1 bits, so the ramp never overshoots or wraps.
    always_comb begin
        act_nxt = I_act;
        diff    = '0;
        if (tick) begin
            if (act_x < tgt_x) begin
                diff    = tgt_x - act_x;
                act_nxt = W'(act_x + ((diff > STEP_X) ? STEP_X : diff));
            end else if (act_x > tgt_x) begin
                diff    = act_x - tgt_x;
                act_nxt = W'(act_x - ((diff > STEP_X) ? STEP_X : diff));
            end
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        listo_nxt = (act_nxt == tgt);
        if (act_nxt < tgt) begin
            state_nxt = ST_SUBIR;
        end else if (act_nxt > tgt) begin
            state_nxt = ST_BAJAR;
        end else if (en) begin
            state_nxt = ST_ESTABLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            listo <= 1'b0;
            I_act <= '0;
        end else begin
            state <= state_nxt;
            listo <= listo_nxt;
            I_act <= act_nxt;
        end
    end

    assign estado = state;

    pwm_gen #(
        .W(W)
    ) u_pwm (
        .clk  (clk),
        .rst  (rst),
        .duty (I_act),
        .pwm  (pwm)
    );

endmodule

// File: tb/tb_rampa_corriente_pwm.sv
// Scoreboard bench for rampa_corriente_pwm (STEP=8, TICK_DIV=4, W=10): stimulus
// queues the expected output tuples, a monitor checks each output change.
module tb_rampa_corriente_pwm;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] I_obj = '0;
    logic [W-1:0] I_act;
    logic         pwm;
    logic         listo;
    logic [1:0]   estado;

    typedef struct packed {
        logic [W-1:0] i;
        logic [1:0]   e;
        logic         l;
    } exp_s;

    exp_s q[$];
    int   checks = 0;
    int   errors = 0;
    bit   snap_req = 1'b0;
    bit   mon_first = 1'b1;
    exp_s mon_cur;
    exp_s mon_prev;
    exp_s mon_exp;
    int   exp_lim;
    int   cyc;

    rampa_corriente_pwm #(
        .W(W),
        .STEP(8),
        .TICK_DIV(4),
        .I_MAX(900)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .I_obj  (I_obj),
        .I_act  (I_act),
        .pwm    (pwm),
        .listo  (listo),
        .estado (estado)
    );

    always #5 clk = ~clk;

    task automatic push(input int i, input int e, input int l);
        exp_s x;
        x.i = i[W-1:0];
        x.e = e[1:0];
        x.l = l[0];
        q.push_back(x);
    endtask

    task automatic push_ramp(input int from, input int to, input int est,
                             input int fin_est, input int fin_listo);
        int v;
        push(from, est, 0);
        v = from;
        while (v != to) begin
            if (v < to) v += ((to - v) > 8) ? 8 : (to - v);
            else        v -= ((v - to) > 8) ? 8 : (v - to);
            if (v == to) push(v, fin_est, fin_listo);
            else         push(v, est, 0);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_settle(input string name, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0) break;
        end
        chk({"settle_", name}, q.size(), 0);
        q.delete();
    endtask

    task automatic measure(input string name, input int exp);
        int cnt;
        cnt = 0;
        repeat (2) @(posedge clk);
        repeat (1023) begin
            @(posedge clk);
            #2;
            if (pwm) cnt++;
        end
        chk(name, cnt, exp);
    endtask

    // Monitor: any change of (I_act, estado, listo), or an explicit snapshot request, pops one entry.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon_cur = {I_act, estado, listo};
            if (mon_first) begin
                mon_prev  = mon_cur;
                mon_first = 1'b0;
            end else if (mon_cur != mon_prev || snap_req) begin
                snap_req = 1'b0;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got I_act=%0d estado=%0d listo=%0d, nothing expected",
                             mon_cur.i, mon_cur.e, mon_cur.l);
                end else begin
                    mon_exp = q.pop_front();
                    if (mon_cur !== mon_exp) begin
                        errors++;
                        $display("FAIL scoreboard: got I_act=%0d estado=%0d listo=%0d, expected I_act=%0d estado=%0d listo=%0d",
                                 mon_cur.i, mon_cur.e, mon_cur.l, mon_exp.i, mon_exp.e, mon_exp.l);
                    end
                end
                mon_prev = mon_cur;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef SOFT_LIMIT_EN
        exp_lim = 900;
`else
        exp_lim = 1000;
`endif
        #2 rst = 1'b0;

        // Reset hold: outputs stay zero.
        repeat (3) begin
            @(negedge clk);
            push(0, 0, 0);
            snap_req = 1'b1;
        end
        chk("reset_pwm", pwm, 0);

        // Ramp 0 -> 100, settling exactly 52 clocks after release.
        @(negedge clk);
        rst   = 1'b1;
        en    = 1'b1;
        I_obj = 10'd100;
        push_ramp(0, 100, 1, 3, 1);
        cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #2;
            if (listo) begin
                cyc = c;
                break;
            end
        end
        chk("ramp_up_100_clocks", cyc, 52);
        wait_settle("up_100", 50);

        // Ramp down 100 -> 20.
        @(negedge clk);
        I_obj = 10'd20;
        push_ramp(100, 20, 2, 3, 1);
        wait_settle("down_20", 100);

        // 20 -> 100, reversed to 0 once the setpoint reaches 60.
        @(negedge clk);
        I_obj = 10'd100;
        push_ramp(20, 60, 1, 1, 0);
        wait_settle("up_to_60", 100);
        @(negedge clk);
        I_obj = 10'd0;
        push_ramp(60, 0, 2, 3, 1);
        wait_settle("reverse_to_0", 100);

        // Up to 60, then disable: ramp down to IDLE.
        @(negedge clk);
        I_obj = 10'd60;
        push_ramp(0, 60, 1, 3, 1);
        wait_settle("up_60", 100);
        @(negedge clk);
        en = 1'b0;
        push_ramp(60, 0, 2, 0, 1);
        wait_settle("disable_down", 100);

        // PWM duty at 512, 0 and 1023.
        @(negedge clk);
        en    = 1'b1;
        I_obj = 10'd512;
        push_ramp(0, 512, 1, 3, 1);
        wait_settle("up_512", 400);
        measure("pwm_512", 512);
        @(negedge clk);
        en = 1'b0;
        push_ramp(512, 0, 2, 0, 1);
        wait_settle("down_0", 400);
        measure("pwm_0", 0);
        @(negedge clk);
        en    = 1'b1;
        I_obj = 10'd1023;
        push_ramp(0, 1023, 1, 3, 1);
        wait_settle("up_1023", 700);
        measure("pwm_1023", 1023);

        // Target 1000: clamped to 900 only with SOFT_LIMIT_EN.
        @(negedge clk);
        I_obj = 10'd1000;
        push_ramp(1023, exp_lim, 2, 3, 1);
        wait_settle("limit", 300);
        chk("limit_I_act", I_act, exp_lim);

        // Reset mid-ramp clears outputs without waiting for a clock.
        @(negedge clk);
        I_obj = 10'd0;
        push(exp_lim, 2, 0);
        push(exp_lim - 8, 2, 0);
        push(exp_lim - 16, 2, 0);
        wait_settle("pre_reset", 50);
        @(negedge clk);
        #2;
        push(0, 0, 0);
        rst = 1'b0;
        #1;
        chk("async_reset_I_act", I_act, 0);
        chk("async_reset_estado", estado, 0);
        chk("async_reset_listo", listo, 0);
        chk("async_reset_pwm", pwm, 0);
        repeat (2) @(negedge clk);
        en = 1'b0;
        push(0, 0, 1);
        rst = 1'b1;
        wait_settle("post_reset", 20);

        repeat (4) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
